// File: rtl/tof_cal_pkg.sv
// tof_cal_pkg: shared width derivations and the FIFO entry layout for the
// multi-hit TDC calibration block (tof_cal_mh) and its fine encoder.
//   fine_w_f(taps)      : fine code width, log2(TAPS)+1 (phase 0..2*TAPS-1)
//   tof_w_f(taps, cw)   : time-stamp / TOF width, COARSE_W + FINE_W
//   idx_w_f(max_hits)   : stop index width, clog2(MAX_HITS+1)
//   TOF_SAT, fifo_ent_t : saturation value and FIFO entry for the default
//                         configuration (TAPS=16, COARSE_W=14, MAX_HITS=6)
package tof_cal_pkg;

  function automatic int fine_w_f(input int taps);
    return $clog2(taps) + 1;
  endfunction

  function automatic int tof_w_f(input int taps, input int cw);
    return cw + fine_w_f(taps);
  endfunction

  function automatic int idx_w_f(input int max_hits);
    return $clog2(max_hits + 1);
  endfunction

  localparam int DEF_TOF_W = tof_w_f(16, 14);
  localparam int DEF_IDX_W = idx_w_f(6);

  // Out-of-range marker: all ones.
  localparam logic [DEF_TOF_W-1:0] TOF_SAT = '1;

  typedef struct packed {
    logic [DEF_TOF_W-1:0] tof;
    logic [DEF_IDX_W-1:0] idx;
  } fifo_ent_t;

endpackage

// File: rtl/tof_fine_enc.sv
// tof_fine_enc: pipelined rotating-thermometer to phase decoder.
// D = log2(TAPS)+1 register stages: stage 1 isolates the lowest edge as a
// one-hot word, each later stage resolves one index bit (MSB first).
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of in-flight valids (stage-1 input kept)
//   in_vld/in_code/in_sb : sample strobe, thermometer word, sideband
//   out_vld/out_p/out_sb : phase 0..2*TAPS-1 and sideband, D cycles later
module tof_fine_enc
  import tof_cal_pkg::*;
#(
  parameter  int TAPS   = 16,
  parameter  int SB_W   = 1,
  localparam int FINE_W = fine_w_f(TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [TAPS-1:0]   in_code,
  input  logic [SB_W-1:0]   in_sb,
  output logic              out_vld,
  output logic [FINE_W-1:0] out_p,
  output logic [SB_W-1:0]   out_sb
);

  localparam int LOG = $clog2(TAPS);
  localparam int D   = LOG + 1;

  // Bits of the one-hot word whose tap index has bit b set.
  function automatic logic [TAPS-1:0] bit_mask(input int b);
    logic [TAPS-1:0] m;
    for (int i = 0; i < TAPS; i++) m[i] = 1'(((i >> b) & 1));
    return m;
  endfunction

  logic [D:1]                  vld_pipe;
  logic [D-1:1][TAPS-1:0]      r_oh;
  logic [D:1][LOG-1:0]         r_idx;
  logic [D:1]                  r_msb;
  logic [D:1][SB_W-1:0]        r_sb;
  logic [TAPS-1:0]             w_v;
  logic [TAPS-1:0]             w_oh;

  // Upper half of the rotation (msb=1) looks for the lowest 1, lower half for
  // the lowest 0; inverting folds both into "lowest 1". The selected word is
  // never zero, and bubbles above the lowest edge are masked by v & -v.
  assign w_v  = in_code[TAPS-1] ? in_code : ~in_code;
  assign w_oh = w_v & (-w_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      r_oh     <= '0;
      r_idx    <= '0;
      r_msb    <= '0;
      r_sb     <= '0;
    end else begin
      // A hit arriving with clr belongs to the new frame, so stage 1 is kept.
      vld_pipe[1] <= in_vld;
      r_oh[1]     <= w_oh;
      r_idx[1]    <= '0;
      r_msb[1]    <= in_code[TAPS-1];
      r_sb[1]     <= in_sb;
      for (int k = 2; k <= D; k++) begin
        vld_pipe[k]     <= vld_pipe[k-1] & ~clr;
        r_msb[k]        <= r_msb[k-1];
        r_sb[k]         <= r_sb[k-1];
        r_idx[k]        <= r_idx[k-1];
        r_idx[k][D-k]   <= |(r_oh[k-1] & bit_mask(D - k));
      end
      for (int k = 2; k < D; k++) r_oh[k] <= r_oh[k-1];
    end
  end

  assign out_vld = vld_pipe[D];
  assign out_p   = {r_msb[D], r_idx[D]};
  assign out_sb  = r_sb[D];

endmodule

// File: rtl/tof_cal_mh.sv
// tof_cal_mh: multi-hit TDC calibration/combination block.
// Decodes each hit to a time stamp {coarse, phase}, keeps the latest start as
// reference, computes stop-start minus the coarse pipeline offset for up to
// MAX_HITS stops per frame, and queues {tof, idx} in a small output FIFO.
// Optional feature macro: TOF_CAL_MH_RANGE_CHK_EN (range check + saturation).
//   clk, rst_n            : clock, async active-low reset
//   frame_start           : opens a new frame (clears frame state, not FIFO)
//   hit_valid/is_start/code/coarse : one sample per cycle
//   range_max             : largest in-range TOF
//   out_valid/out_ready/out_tof/out_idx : FIFO head handshake
//   hit_cnt, frame_ovf    : in-range stop count, sticky overflow flag
module tof_cal_mh
  import tof_cal_pkg::*;
#(
  parameter  int TAPS       = 16,
  parameter  int COARSE_W   = 14,
  parameter  int COARSE_OFS = 1,
  parameter  int MAX_HITS   = 6,
  parameter  int FIFO_DEPTH = 4,
  localparam int FINE_W     = fine_w_f(TAPS),
  localparam int TOF_W      = tof_w_f(TAPS, COARSE_W),
  localparam int IDX_W      = idx_w_f(MAX_HITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                hit_valid,
  input  logic                hit_is_start,
  input  logic [TAPS-1:0]     hit_code,
  input  logic [COARSE_W-1:0] hit_coarse,
  input  logic [TOF_W-1:0]    range_max,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TOF_W-1:0]    out_tof,
  output logic [IDX_W-1:0]    out_idx,
  output logic [IDX_W-1:0]    hit_cnt,
  output logic                frame_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TOF_W-1:0] OFS_T    = TOF_W'(COARSE_OFS << FINE_W);
  localparam logic [IDX_W-1:0] HIT_MAX  = IDX_W'(MAX_HITS);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [TOF_W-1:0] tof;
    logic [IDX_W-1:0] idx;
  } ent_t;

  // ---- decode ----
  logic                w_dec_vld;
  logic [FINE_W-1:0]   w_dec_p;
  logic [COARSE_W:0]   w_dec_sb;
  logic [TOF_W-1:0]    w_stamp;
  logic                w_dec_start;

  tof_fine_enc #(.TAPS(TAPS), .SB_W(COARSE_W + 1)) u_enc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (frame_start),
    .in_vld  (hit_valid),
    .in_code (hit_code),
    .in_sb   ({hit_is_start, hit_coarse}),
    .out_vld (w_dec_vld),
    .out_p   (w_dec_p),
    .out_sb  (w_dec_sb)
  );

  assign w_dec_start = w_dec_sb[COARSE_W];
  assign w_stamp     = {w_dec_sb[COARSE_W-1:0], w_dec_p};

  // ---- frame state + subtraction stage ----
  logic              r_start_ok;
  logic [TOF_W-1:0]  r_ref;
  logic [IDX_W-1:0]  r_stop_idx;
  logic              r_sub_vld, r_sub_ovf;
  logic [TOF_W-1:0]  r_sub_tof;
  logic [IDX_W-1:0]  r_sub_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_ok <= 1'b0;
      r_ref      <= '0;
      r_stop_idx <= '0;
      r_sub_vld  <= 1'b0;
      r_sub_ovf  <= 1'b0;
      r_sub_tof  <= '0;
      r_sub_idx  <= '0;
    end else if (frame_start) begin
      // Decoder output this cycle is an in-flight hit of the old frame.
      r_start_ok <= 1'b0;
      r_stop_idx <= '0;
      r_sub_vld  <= 1'b0;
      r_sub_ovf  <= 1'b0;
    end else begin
      r_sub_vld <= 1'b0;
      r_sub_ovf <= 1'b0;
      if (w_dec_vld) begin
        if (w_dec_start) begin
          r_ref      <= w_stamp;
          r_start_ok <= 1'b1;
          r_stop_idx <= '0;
        end else if (r_start_ok) begin
          if (r_stop_idx == HIT_MAX) begin
            r_sub_ovf <= 1'b1;
          end else begin
            r_stop_idx <= r_stop_idx + IDX_ONE;
            r_sub_vld  <= 1'b1;
            r_sub_idx  <= r_stop_idx + IDX_ONE;
            // Modulo 2^TOF_W: fine borrow and coarse wrap need no special case.
            r_sub_tof  <= w_stamp - r_ref - OFS_T;
          end
        end
      end
    end
  end

  // ---- range / saturate stage ----
  logic              w_in_range;
  logic              r_sat_vld, r_sat_ovf, r_sat_in;
  logic [TOF_W-1:0]  r_sat_tof;
  logic [IDX_W-1:0]  r_sat_idx;

`ifdef TOF_CAL_MH_RANGE_CHK_EN
  assign w_in_range = (r_sub_tof <= range_max);
`else
  // range_max has no effect in this build; the OR keeps it formally read.
  assign w_in_range = 1'b1 | (&range_max);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_vld <= 1'b0;
      r_sat_ovf <= 1'b0;
      r_sat_in  <= 1'b0;
      r_sat_tof <= '0;
      r_sat_idx <= '0;
    end else begin
      r_sat_vld <= r_sub_vld & ~frame_start;
      r_sat_ovf <= r_sub_ovf & ~frame_start;
      r_sat_in  <= w_in_range;
      r_sat_tof <= w_in_range ? r_sub_tof : '1;
      r_sat_idx <= r_sub_idx;
    end
  end

  // ---- output FIFO + frame counters ----
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt;
  ent_t          r_mem [FIFO_DEPTH];
  ent_t          w_head;
  logic          w_push, w_pop, w_full, w_wr;

  assign w_push = r_sat_vld & ~frame_start;
  assign w_pop  = out_valid & out_ready;
  assign w_full = (r_cnt == CNT_FULL);
  // A pop in the same cycle frees the slot, so full+pop still writes.
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      hit_cnt   <= '0;
      frame_ovf <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      if (frame_start) begin
        hit_cnt   <= '0;
        frame_ovf <= 1'b0;
      end else begin
        if (w_push && r_sat_in) hit_cnt <= hit_cnt + IDX_ONE;
        if (r_sat_ovf || (w_push && !w_wr)) frame_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= '{tof: r_sat_tof, idx: r_sat_idx};
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign out_valid = (r_cnt != '0);
  assign out_tof   = out_valid ? w_head.tof : '0;
  assign out_idx   = out_valid ? w_head.idx : '0;

endmodule

// File: tb/tb_tof_cal_mh.sv
module tb_tof_cal_mh;
  import tof_cal_pkg::*;

  logic        clk, rst_n, frame_start, hit_valid, hit_is_start;
  logic [15:0] hit_code;
  logic [13:0] hit_coarse;
  logic [18:0] range_max, out_tof;
  logic        out_valid, out_ready, frame_ovf;
  logic [2:0]  out_idx, hit_cnt;

  tof_cal_mh #(.TAPS(16), .COARSE_W(14), .COARSE_OFS(1), .MAX_HITS(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .hit_valid(hit_valid),
    .hit_is_start(hit_is_start), .hit_code(hit_code), .hit_coarse(hit_coarse),
    .range_max(range_max), .out_valid(out_valid), .out_ready(out_ready),
    .out_tof(out_tof), .out_idx(out_idx), .hit_cnt(hit_cnt), .frame_ovf(frame_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  fifo_ent_t sb_q[$];

  // reference model state
  bit          m_ok, m_ovf, hold;
  logic [18:0] m_ref;
  int          m_idx, m_hit;

  function automatic int phase(input logic [15:0] c);
    int p;
    p = 0;
    if (c[15] == 1'b0) begin
      for (int i = 15; i >= 0; i--) if (c[i] == 1'b0) p = i;
    end else begin
      for (int i = 15; i >= 0; i--) if (c[i] == 1'b1) p = 16 + i;
    end
    return p;
  endfunction

  task automatic send(input bit st, input logic [15:0] code, input int coarse);
    logic [18:0] s, tof;
    bit inr;
    s = {coarse[13:0], 5'(phase(code))};
    hit_valid = 1'b1; hit_is_start = st; hit_code = code; hit_coarse = coarse[13:0];
    if (st) begin
      m_ref = s; m_ok = 1'b1; m_idx = 0;
    end else if (m_ok) begin
      if (m_idx == 6) m_ovf = 1'b1;
      else begin
        m_idx++;
        tof = s - m_ref - 19'd32;
`ifdef TOF_CAL_MH_RANGE_CHK_EN
        inr = (tof <= range_max);
`else
        inr = 1'b1;
`endif
        if (inr) m_hit++;
        else tof = TOF_SAT;
        if (hold && sb_q.size() >= 4) m_ovf = 1'b1;
        else sb_q.push_back('{tof: tof, idx: 3'(m_idx)});
      end
    end
    @(posedge clk); #1;
    hit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    m_ok = 0; m_idx = 0; m_hit = 0; m_ovf = 0;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries still expected, required 0", name, sb_q.size());
      sb_q.delete();
    end
    idle(4);
  endtask

  task automatic chk_frame(input string name);
    n_chk++;
    if (hit_cnt !== 3'(m_hit)) begin
      n_fail++; $display("FAIL %s_hit_cnt: got %0d required %0d", name, hit_cnt, m_hit);
    end
    n_chk++;
    if (frame_ovf !== m_ovf) begin
      n_fail++; $display("FAIL %s_frame_ovf: got %0b required %0b", name, frame_ovf, m_ovf);
    end
  endtask

  // scoreboard monitor: pop happens on the next posedge when valid && ready
  fifo_ent_t e;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: tof %0d idx %0d, no entry expected", out_tof, out_idx);
      end else begin
        e = sb_q.pop_front();
        if (out_tof !== e.tof || out_idx !== e.idx) begin
          n_fail++;
          $display("FAIL out_entry: tof %0d idx %0d, required tof %0d idx %0d",
                   out_tof, out_idx, e.tof, e.idx);
        end
      end
    end
  end

  task automatic test_reset();
    n_chk++;
    if ({out_valid, out_tof, out_idx, hit_cnt, frame_ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid %0b tof %0d idx %0d cnt %0d ovf %0b, required all 0",
               out_valid, out_tof, out_idx, hit_cnt, frame_ovf);
    end
  endtask

  task automatic test_basic();
    int lat;
    new_frame();
    send(1, 16'h00FF, 100);
    idle(2);
    send(0, 16'h0FFF, 103);
    lat = 1;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    n_chk++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d required 8", lat); end
    n_chk++;
    if (out_tof !== 19'd68 || out_idx !== 3'd1) begin
      n_fail++; $display("FAIL basic_value: tof %0d idx %0d, required 68 1", out_tof, out_idx);
    end
    drain("basic");
    chk_frame("basic");
  endtask

  task automatic test_fine_borrow();
    new_frame();
    send(1, 16'h0FFF, 100);
    send(0, 16'h0007, 102);   // immediately after start: uses new reference
    drain("borrow");
    chk_frame("borrow");
  endtask

  task automatic test_upper_wrap();
    new_frame();
    send(1, 16'h0000, 50);
    send(0, 16'hFFF0, 51);
    drain("upper");
    new_frame();
    send(1, 16'h0000, 16383);
    send(0, 16'h0000, 1);
    drain("wrap");
    chk_frame("wrap");
  endtask

  task automatic test_range();
    range_max = 19'd100;
    new_frame();
    send(1, 16'h0000, 0);
    send(0, 16'hFFF0, 16);    // TOF 500
    send(0, 16'h0000, 3);     // TOF 64
    drain("range");
    chk_frame("range");
    range_max = '1;
  endtask

  task automatic test_seven_stops();
    new_frame();
    send(1, 16'h0000, 10);
    for (int i = 0; i < 7; i++) send(0, 16'h00FF >> i, 12 + i);
    drain("seven");
    chk_frame("seven");
    new_frame();
    idle(2);
    chk_frame("seven_clear");
  endtask

  task automatic test_back_pressure();
    hold = 1; out_ready = 1'b0;
    new_frame();
    send(1, 16'h0003, 200);
    for (int i = 0; i < 5; i++) send(0, 16'hFF00 << i, 202 + i);
    idle(10);
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b required 1", out_valid); end
    chk_frame("bp");
    hold = 0; out_ready = 1'b1;
    drain("bp");
  endtask

  task automatic test_reset_mid();
    hold = 1; out_ready = 1'b0;
    new_frame();
    send(1, 16'h0000, 300);
    for (int i = 0; i < 3; i++) send(0, 16'h0001, 302 + i);
    idle(4);
    rst_n = 1'b0;
    #1;
    test_reset();
    sb_q.delete();
    m_ok = 0; m_idx = 0; m_hit = 0; m_ovf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; hold = 0; out_ready = 1'b1;
    idle(12);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_empty: valid %0b required 0", out_valid); end
    chk_frame("rstmid");
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; hit_valid = 1'b0; hit_is_start = 1'b0;
    hit_code = '0; hit_coarse = '0; range_max = '1; out_ready = 1'b1; hold = 0;
    m_ok = 0; m_idx = 0; m_hit = 0; m_ovf = 0; m_ref = '0;
    idle(3);
    test_reset();
    rst_n = 1'b1;
    idle(2);
    test_reset();
    test_basic();
    test_fine_borrow();
    test_upper_wrap();
    test_range();
    test_seven_stops();
    test_back_pressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
